neuron_out_streamer: RTL and testbench

Reads back a bank of N registered W-bit neuron outputs and streams them one word per transfer over a valid/ready handshake. Sits at the output end of the network datapath: the capture registers write neuron results in parallel, and this block drains them serially to the downstream consumer (output port, next layer's input loader or debug tap). One parallel snapshot is taken per `load`. The bank is then emitted in index order 0..N-1, with `out_last` flagging the final word.

---
 rtl/neuron_out_streamer_if.sv | 27 ++
 rtl/neuron_out_streamer.sv | 75 +++++++
 tb/tb_neuron_out_streamer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_out_streamer_if.sv
// Handshake bundle between the neuron capture bank, the streamer and the downstream consumer.
// The streamer is the master: it owns the stream outputs and status flags.
interface neuron_out_streamer_if #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = 2
);
  logic            load;
  logic [N*W-1:0]  data_in;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            busy;
  logic            done;

  modport master (
    input  load, data_in, out_ready,
    output out_data, out_valid, out_idx, out_last, busy, done
  );

  modport slave (
    output load, data_in, out_ready,
    input  out_data, out_valid, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/neuron_out_streamer.sv
// Snapshots a bank of N neuron outputs on load and drains it word by word, index 0..N-1,
// over a valid/ready stream; all outputs decode from registered state only.
module neuron_out_streamer #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = 2
) (
  input  logic                   clo,
  input  logic                   res,
  neuron_out_streamer_if.master  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N*W-1:0]  snap_q, snap_d;
  logic            done_q, done_d;

  always_ff @(posedge clo or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  // idx returns to 0 after the final word so IDLE outputs need no extra clearing of idx.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          snap_d  = bus.data_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic sending;
  assign sending = (state_q == SEND);

  assign bus.out_valid = sending;
  assign bus.busy      = sending;
  assign bus.done      = done_q;
  assign bus.out_idx   = sending ? idx_q : '0;
  assign bus.out_last  = sending && (idx_q == LastIdx);
  assign bus.out_data  = sending ? snap_q[idx_q*W +: W] : '0;

endmodule

// File: tb/tb_neuron_out_streamer.sv
// Self-checking bench: queue-based reference model compared every cycle, directed scenarios
// pinned with literal word expectations, then a randomized load/ready/data phase.
module tb_neuron_out_streamer;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic clo;
  logic res;

  int checks = 0;
  int errors = 0;

  neuron_out_streamer_if #(.N(N), .W(W), .IW(IW)) bus ();

  neuron_out_streamer #(.N(N), .W(W), .IW(IW)) dut (
    .clo (clo),
    .res (res),
    .bus (bus.master)
  );

  initial clo = 1'b0;
  always #5 clo = ~clo;

  // Reference model: a loaded bank becomes a queue of pending words, popped per transfer.
  logic [W-1:0] pending[$];
  logic         mDone;

  always @(posedge clo or posedge res) begin
    if (res) begin
      pending.delete();
      mDone = 1'b0;
    end else begin
      mDone = 1'b0;
      if (pending.size() == 0) begin
        if (bus.load) begin
          for (int i = 0; i < N; i++) begin
            logic [N*W-1:0] bank;
            bank = bus.data_in;
            pending.push_back(bank[i*W +: W]);
          end
        end
      end else if (bus.out_ready) begin
        if (pending.size() == 1) mDone = 1'b1;
        void'(pending.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clo) begin
    logic        expValid;
    logic [W-1:0] expData;
    logic [IW-1:0] expIdx;
    expValid = (pending.size() > 0);
    expData  = expValid ? pending[0] : '0;
    expIdx   = expValid ? IW'(N - pending.size()) : '0;
    checkOutput("model_valid", 32'(bus.out_valid), 32'(expValid));
    checkOutput("model_busy",  32'(bus.busy),      32'(expValid));
    checkOutput("model_data",  32'(bus.out_data),  32'(expData));
    checkOutput("model_idx",   32'(bus.out_idx),   32'(expIdx));
    checkOutput("model_last",  32'(bus.out_last),  32'(pending.size() == 1));
    checkOutput("model_done",  32'(bus.done),      32'(mDone));
  end

  task automatic applyStimulus(input logic ld, input logic [N*W-1:0] data, input logic rdy);
    bus.load      = ld;
    bus.data_in   = data;
    bus.out_ready = rdy;
  endtask

  task automatic expectWord(input string name, input int idx, input logic [W-1:0] word);
    checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({name, "_data"},  32'(bus.out_data),  32'(word));
    checkOutput({name, "_idx"},   32'(bus.out_idx),   32'(idx));
    checkOutput({name, "_last"},  32'(bus.out_last),  32'(idx == N - 1));
    checkOutput({name, "_done"},  32'(bus.done),      32'd0);
  endtask

  task automatic expectIdle(input string name, input logic doneWant);
    checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, "_busy"},  32'(bus.busy),      32'd0);
    checkOutput({name, "_data"},  32'(bus.out_data),  32'd0);
    checkOutput({name, "_idx"},   32'(bus.out_idx),   32'd0);
    checkOutput({name, "_last"},  32'(bus.out_last),  32'd0);
    checkOutput({name, "_done"},  32'(bus.done),      32'(doneWant));
  endtask

  logic [W-1:0] wordsA5C3[N];
  logic [W-1:0] words1234[N];
  logic [W-1:0] words0F0F[N];

  initial begin
    wordsA5C3 = '{4'h3, 4'hC, 4'h5, 4'hA};
    words1234 = '{4'h4, 4'h3, 4'h2, 4'h1};
    words0F0F = '{4'hF, 4'h0, 4'hF, 4'h0};

    res = 1'b1;
    applyStimulus(1'b1, 16'hA5C3, 1'b1);
    repeat (2) @(negedge clo);
    expectIdle("reset", 1'b0);
    res = 1'b0;

    // Idle quiescence with random noise on data and ready
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 16'($urandom), 1'($urandom));
      @(negedge clo);
      expectIdle("idle", 1'b0);
    end

    // Basic drain, then back-to-back load in the done cycle
    applyStimulus(1'b1, 16'hA5C3, 1'b1);
    @(negedge clo);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < N; i++) begin
      expectWord("drain", i, wordsA5C3[i]);
      @(negedge clo);
    end
    expectIdle("drain_done", 1'b1);
    applyStimulus(1'b1, 16'h1234, 1'b1);
    @(negedge clo);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < N; i++) begin
      expectWord("b2b", i, words1234[i]);
      @(negedge clo);
    end
    expectIdle("b2b_done", 1'b1);
    @(negedge clo);
    expectIdle("b2b_after", 1'b0);

    // Backpressure at idx 1 with an ignored load of FFFF
    applyStimulus(1'b1, 16'hA5C3, 1'b1);
    @(negedge clo);
    applyStimulus(1'b0, 16'hA5C3, 1'b1);
    expectWord("bp", 0, wordsA5C3[0]);
    @(negedge clo);
    expectWord("bp", 1, wordsA5C3[1]);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clo);
      expectWord("bp_hold", 1, wordsA5C3[1]);
    end
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    @(negedge clo);
    expectWord("bp", 2, wordsA5C3[2]);
    @(negedge clo);
    expectWord("bp", 3, wordsA5C3[3]);
    applyStimulus(1'b0, 16'hFFFF, 1'b1);
    @(negedge clo);
    expectIdle("bp_done", 1'b1);
    @(negedge clo);
    expectIdle("bp_single_done", 1'b0);

    // Asynchronous reset while idx 2 is presented
    applyStimulus(1'b1, 16'hA5C3, 1'b1);
    @(negedge clo);
    applyStimulus(1'b0, 16'hA5C3, 1'b1);
    @(negedge clo);
    @(negedge clo);
    expectWord("pre_rst", 2, wordsA5C3[2]);
    #1 res = 1'b1;
    #1 expectIdle("async_rst", 1'b0);
    @(negedge clo);
    res = 1'b0;
    @(negedge clo);
    expectIdle("post_rst", 1'b0);
    @(negedge clo);
    expectIdle("post_rst_no_done", 1'b0);
    applyStimulus(1'b1, 16'h0F0F, 1'b1);
    @(negedge clo);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < N; i++) begin
      expectWord("reload", i, words0F0F[i]);
      @(negedge clo);
    end
    expectIdle("reload_done", 1'b1);

    // Randomized traffic checked by the reference model
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'(($urandom % 3) == 0), 16'($urandom), 1'(($urandom % 4) != 0));
      @(negedge clo);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (N + 2) @(negedge clo);
    expectIdle("final_idle", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
